// File: rtl/pa_interchange_pkg.sv
// Shared types and constants for the privacy-amplification interchange
// permutation control path.
package pa_interchange_pkg;

  localparam int LEN_W      = 13;
  localparam int ADDR_W     = 12;
  localparam int STAGE_W    = 4;
  localparam int CC_W       = STAGE_W + ADDR_W;
  localparam int MAX_STAGES = 4;
  localparam int MAX_LEN    = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  function automatic logic cfg_legal(input logic [LEN_W-1:0] len,
                                     input logic [2:0]       stages);
    return (len != '0) && (len <= LEN_W'(MAX_LEN)) &&
           (stages != '0) && (stages <= 3'(MAX_STAGES));
  endfunction

  // Interchange expects the stage in the upper field, beat address below.
  function automatic logic [CC_W-1:0] pack_cycle_count(input logic [STAGE_W-1:0] stage,
                                                       input logic [ADDR_W-1:0]  addr);
    return {stage, addr};
  endfunction

endpackage

// File: rtl/interchange_beat_counter.sv
// Beat address and stage counters with the latched run configuration and
// terminal flags used by the sequencer FSM.
module interchange_beat_counter
  import pa_interchange_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [2:0]         load_stages,
  input  logic               adv,
  input  logic               stage_adv,
  output logic [ADDR_W-1:0]  addr,
  output logic [STAGE_W-1:0] stage,
  output logic               last_beat,
  output logic               last_stage
);

  logic [ADDR_W-1:0]  addr_q;
  logic [STAGE_W-1:0] stage_q;
  logic [ADDR_W-1:0]  len_m1_q;
  logic [STAGE_W-1:0] stages_m1_q;

  assign last_beat  = (addr_q == len_m1_q);
  assign last_stage = (stage_q == stages_m1_q);
  assign addr       = addr_q;
  assign stage      = stage_q;

  // NOTE: every register here, configuration included, is reset asynchronously
  // so the block is fully defined the instant reset asserts; state updates use
  // non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      stage_q     <= '0;
      len_m1_q    <= '0;
      stages_m1_q <= '0;
    end else if (clear) begin
      addr_q      <= '0;
      stage_q     <= '0;
      len_m1_q    <= '0;
      stages_m1_q <= '0;
    end else if (load) begin
      addr_q      <= '0;
      stage_q     <= '0;
      // Legal lengths are 1..4096, so len-1 always fits the address width.
      len_m1_q    <= ADDR_W'(load_len - LEN_W'(1));
      stages_m1_q <= STAGE_W'(load_stages) - STAGE_W'(1);
    end else begin
      if (adv)       addr_q  <= last_beat ? '0 : addr_q + ADDR_W'(1);
      if (stage_adv) stage_q <= stage_q + STAGE_W'(1);
    end
  end

endmodule

// File: rtl/interchange_sequencer.sv
// Sequences read / interchange / in-place write-back of every beat over a
// configurable number of permutation stages in the 16-bank memory.
module interchange_sequencer
  import pa_interchange_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [2:0]        cfg_stages,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       cycle_count,
  output logic              ic_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  seq_state_t         state_q, state_d;
  logic               legal;
  logic               accept;
  logic               issue;
  logic               stage_adv;
  logic               drain_exit;
  logic [ADDR_W-1:0]  addr;
  logic [STAGE_W-1:0] stage;
  logic               last_beat;
  logic               last_stage;

  logic               v1_q, v2_q;
  logic [CC_W-1:0]    cc1_q;
  logic [ADDR_W-1:0]  wr_addr_q;

  assign legal  = cfg_legal(cfg_len, cfg_stages);
  assign accept = (state_q == ST_IDLE) && start && !abort && legal;
  assign issue  = rd_req && rd_gnt;

  // The beat in v2 is written at the end of this cycle, so once v1 is empty
  // the next stage may read in the following cycle without seeing stale data.
  assign drain_exit = (state_q == ST_DRAIN) && !v1_q;
  assign stage_adv  = drain_exit && !last_stage && !abort;

  interchange_beat_counter u_beat_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (abort),
    .load        (accept),
    .load_len    (cfg_len),
    .load_stages (cfg_stages),
    .adv         (issue),
    .stage_adv   (stage_adv),
    .addr        (addr),
    .stage       (stage),
    .last_beat   (last_beat),
    .last_stage  (last_stage)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (accept) state_d = ST_RUN;
        ST_RUN:   if (issue && last_beat) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_exit) state_d = last_stage ? ST_DONE : ST_RUN;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_req  = (state_q == ST_RUN);
    busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
    cfg_err = (state_q == ST_IDLE) && start && !abort && !legal;
  end

  // Read data returns one cycle after grant; the interchange adds one more.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      cc1_q     <= '0;
      wr_addr_q <= '0;
    end else if (abort) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      cc1_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      v1_q <= issue;
      v2_q <= v1_q;
      if (issue) cc1_q     <= pack_cycle_count(stage, addr);
      if (v1_q)  wr_addr_q <= cc1_q[ADDR_W-1:0];
    end
  end

  assign rd_addr     = addr;
  assign cycle_count = cc1_q;
  assign ic_valid    = v1_q;
  assign wr_en       = v2_q;
  assign wr_addr     = wr_addr_q;

endmodule
